// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Bundles every non-clock, non-reset signal of the KGP-miniRISC instruction
// sequencer into one interface.
//   master modport : the sequencer side. It receives start, the memory ready
//                    handshakes, the decoder controls, alu_result and alu_flags.
//                    It drives pc, the memory request strobes, reg_we, flags,
//                    halted, state and retired.
//   slave modport  : the surrounding datapath and memories, or a testbench.
//                    Same signals with the directions reversed.
// ---------------------------------------------------------------------------
interface pc_sequencer_if;
    logic        start;
    logic        imem_ready;
    logic        dmem_ready;
    logic        is_halt;
    logic        is_mem;
    logic        is_store;
    logic        writes_reg;
    logic        set_flags;
    logic        unconditional;
    logic [2:0]  conditional;
    logic        ad_sel;
    logic [31:0] jump_addr;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;

    logic [31:0] pc;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_we;
    logic [2:0]  flags;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] retired;

    modport master (
        input  start, imem_ready, dmem_ready, is_halt, is_mem, is_store,
               writes_reg, set_flags, unconditional, conditional, ad_sel,
               jump_addr, alu_result, alu_flags,
        output pc, imem_req, ir_load, dmem_req, dmem_we, reg_we, flags,
               halted, state, retired
    );

    modport slave (
        output start, imem_ready, dmem_ready, is_halt, is_mem, is_store,
               writes_reg, set_flags, unconditional, conditional, ad_sel,
               jump_addr, alu_result, alu_flags,
        input  pc, imem_req, ir_load, dmem_req, dmem_we, reg_we, flags,
               halted, state, retired
    );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle instruction sequencer for KGP-miniRISC. It owns the program
// counter, the {carry, zero, sign} flag register, the retired-instruction
// counter and the FETCH/DECODE/EXEC/MEM/WB state machine. It resolves
// branches and drives the memory and register-file strobes.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : pc_sequencer_if.master. It carries the start, handshake,
//           decoder and ALU inputs, and the pc, strobe, flag, halted,
//           state and retired outputs.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] retired_q, retired_d;
    logic [2:0]  flags_q, flags_d;
    logic        imem_req_q, imem_req_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic        reg_we_q, reg_we_d;
    logic        halted_q, halted_d;

    logic        cond_met;
    logic        taken;
    logic [31:0] target;

    // The branch condition uses the flags held before this instruction's
    // own flag update. The flag bit order is {carry, zero, sign}.
    always_comb begin
        cond_met = 1'b0;
        case (bus.conditional)
            3'b001:  cond_met = flags_q[1];
            3'b010:  cond_met = ~flags_q[1];
            3'b011:  cond_met = flags_q[2];
            3'b100:  cond_met = ~flags_q[2];
            3'b101:  cond_met = flags_q[0];
            default: cond_met = 1'b0;
        endcase
    end

    assign taken  = bus.unconditional | cond_met;
    assign target = bus.ad_sel ? bus.alu_result : bus.jump_addr;

    // Next-state and datapath update logic.
    // The strobes are computed from the next state so that the registered
    // copy always equals a decode of the current state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        retired_d = retired_q;
        flags_d   = flags_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = bus.is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                next_pc_d = taken ? target : pc_q + PC_STEP;
                if (bus.set_flags) flags_d = bus.alu_flags;
                state_d = bus.is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (bus.dmem_ready) state_d = S_WB;
            end
            S_WB: begin
                pc_d      = next_pc_q;
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Encoding 7 is unreachable. It falls back to IDLE.
                state_d = S_IDLE;
            end
        endcase

        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        dmem_we_d  = (state_d == S_MEM) && bus.is_store;
        reg_we_d   = (state_d == S_WB) && bus.writes_reg;
        halted_d   = (state_d == S_HALT);
    end

    // State, program counter, flags and registered strobes.
    // A synchronous reset takes priority over all other events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            next_pc_q  <= 32'd0;
            retired_q  <= 32'd0;
            flags_q    <= 3'd0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            next_pc_q  <= next_pc_d;
            retired_q  <= retired_d;
            flags_q    <= flags_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            reg_we_q   <= reg_we_d;
            halted_q   <= halted_d;
        end
    end

    // ir_load follows imem_ready within the same FETCH cycle.
    assign bus.ir_load  = imem_req_q & bus.imem_ready;
    assign bus.pc       = pc_q;
    assign bus.imem_req = imem_req_q;
    assign bus.dmem_req = dmem_req_q;
    assign bus.dmem_we  = dmem_we_q;
    assign bus.reg_we   = reg_we_q;
    assign bus.flags    = flags_q;
    assign bus.halted   = halted_q;
    assign bus.state    = state_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Testbench for pc_sequencer. It uses directed and random instructions.
// Each instruction's expected retirement record is queued. A monitor
// compares that record when the retired counter advances.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    typedef struct {
        bit        halt;
        bit        mem;
        bit        store;
        bit        wr;
        bit        setf;
        bit        uncond;
        bit [2:0]  cond;
        bit        adsel;
        bit [31:0] jaddr;
        bit [31:0] alu;
        bit [2:0]  aflags;
    } instr_t;

    typedef struct {
        bit [31:0] pc;
        bit [2:0]  flags;
        bit [31:0] retired;
        int        reg_we_cyc;
        int        imem_cyc;
        int        ir_load_cyc;
        int        dmem_cyc;
        int        dmem_we_cyc;
        int        busy_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Architectural reference state
    bit [31:0] m_pc;
    bit [2:0]  m_flags;
    bit [31:0] m_retired;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Branch condition rule in terms of named flags
    function automatic bit condHolds(input bit [2:0] code, input bit [2:0] f);
        bit carry, zero, sign;
        carry = f[2];
        zero  = f[1];
        sign  = f[0];
        case (code)
            3'b001:  return zero;
            3'b010:  return !zero;
            3'b011:  return carry;
            3'b100:  return !carry;
            3'b101:  return sign;
            default: return 1'b0;
        endcase
    endfunction

    function automatic instr_t aluOp();
        instr_t i;
        i = '{default: '0};
        i.wr = 1'b1;
        return i;
    endfunction

    function automatic instr_t randInstr();
        instr_t i;
        i.halt   = 1'b0;
        i.mem    = ($urandom_range(2) == 0);
        i.store  = $urandom_range(1);
        i.wr     = $urandom_range(1);
        i.setf   = $urandom_range(1);
        i.uncond = ($urandom_range(7) == 0);
        i.cond   = 3'($urandom_range(7));
        i.adsel  = $urandom_range(1);
        i.jaddr  = $urandom;
        i.alu    = $urandom;
        i.aflags = 3'($urandom_range(7));
        return i;
    endfunction

    task automatic resetModel();
        m_pc      = 32'h0;
        m_flags   = 3'd0;
        m_retired = 32'd0;
        sb.delete();
    endtask

    task automatic driveFields(input instr_t i);
        bus.is_halt       = i.halt;
        bus.is_mem        = i.mem;
        bus.is_store      = i.store;
        bus.writes_reg    = i.wr;
        bus.set_flags     = i.setf;
        bus.unconditional = i.uncond;
        bus.conditional   = i.cond;
        bus.ad_sel        = i.adsel;
        bus.jump_addr     = i.jaddr;
        bus.alu_result    = i.alu;
        bus.alu_flags     = i.aflags;
    endtask

    task automatic waitState(input logic [2:0] s, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.state == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checkOutput(name, 32'(ok), 32'd1);
    endtask

    // Issues one instruction. The instruction memory answers after
    // imem_wait stall cycles and the data memory after dmem_wait stall
    // cycles. The expected retirement record is queued first, then the
    // handshakes are driven until the next FETCH or HALT.
    task automatic applyStimulus(input instr_t i, input int imem_wait, input int dmem_wait);
        exp_t e;
        bit   taken, ok, left;
        int   fcnt, mcnt;
        waitState(3'd1, "enter_fetch");
        driveFields(i);
        if (!i.halt) begin
            taken = i.uncond || condHolds(i.cond, m_flags);
            m_pc  = taken ? (i.adsel ? i.alu : i.jaddr) : m_pc + 32'd1;
            if (i.setf) m_flags = i.aflags;
            m_retired++;
            e.pc          = m_pc;
            e.flags       = m_flags;
            e.retired     = m_retired;
            e.reg_we_cyc  = i.wr ? 1 : 0;
            e.imem_cyc    = imem_wait + 1;
            e.ir_load_cyc = 1;
            e.dmem_cyc    = i.mem ? dmem_wait + 1 : 0;
            e.dmem_we_cyc = (i.mem && i.store) ? dmem_wait + 1 : 0;
            e.busy_cyc    = imem_wait + 4 + (i.mem ? dmem_wait + 1 : 0);
            sb.push_back(e);
        end
        fcnt = 0;
        mcnt = 0;
        ok   = 1'b0;
        left = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.imem_ready = 1'b0;
            bus.dmem_ready = 1'b0;
            if (bus.state == 3'd1) begin
                bus.imem_ready = (fcnt == imem_wait);
                fcnt++;
            end else if (bus.state == 3'd4) begin
                bus.dmem_ready = (mcnt == dmem_wait);
                mcnt++;
            end
            tick();
            if (bus.state != 3'd1) left = 1'b1;
            if ((left && bus.state == 3'd1) || bus.state == 3'd6) begin
                ok = 1'b1;
                break;
            end
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        checkOutput("instr_completes", 32'(ok), 32'd1);
    endtask

    // Monitor: accumulates strobe activity between retirements and checks
    // each retirement against the oldest queued expectation.
    initial begin : monitor
        int        n_rw, n_im, n_irl, n_dm, n_dw, n_busy;
        bit [31:0] prev_ret;
        exp_t      e;
        n_rw = 0; n_im = 0; n_irl = 0; n_dm = 0; n_dw = 0; n_busy = 0;
        prev_ret = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n_rw = 0; n_im = 0; n_irl = 0; n_dm = 0; n_dw = 0; n_busy = 0;
                prev_ret = 32'd0;
            end else begin
                if (bus.retired != prev_ret) begin
                    prev_ret = bus.retired;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_retire: got retired=%0d, expected none", bus.retired);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("ret_pc", bus.pc, e.pc);
                        checkOutput("ret_flags", 32'(bus.flags), 32'(e.flags));
                        checkOutput("ret_count", bus.retired, e.retired);
                        checkOutput("ret_reg_we_cycles", n_rw, e.reg_we_cyc);
                        checkOutput("ret_imem_req_cycles", n_im, e.imem_cyc);
                        checkOutput("ret_ir_load_cycles", n_irl, e.ir_load_cyc);
                        checkOutput("ret_dmem_req_cycles", n_dm, e.dmem_cyc);
                        checkOutput("ret_dmem_we_cycles", n_dw, e.dmem_we_cyc);
                        checkOutput("ret_busy_cycles", n_busy, e.busy_cyc);
                    end
                    n_rw = 0; n_im = 0; n_irl = 0; n_dm = 0; n_dw = 0; n_busy = 0;
                end
                if (bus.state >= 3'd1 && bus.state <= 3'd5) n_busy++;
                if (bus.reg_we)   n_rw++;
                if (bus.imem_req) n_im++;
                if (bus.ir_load)  n_irl++;
                if (bus.dmem_req) n_dm++;
                if (bus.dmem_we)  n_dw++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        instr_t    i;
        bit [31:0] halt_pc, halt_ret;

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        driveFields(aluOp());
        resetModel();
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_state", 32'(bus.state), 32'd0);
        checkOutput("reset_pc", bus.pc, 32'h0);
        checkOutput("reset_flags", 32'(bus.flags), 32'd0);
        checkOutput("reset_retired", bus.retired, 32'd0);
        checkOutput("reset_halted", 32'(bus.halted), 32'd0);
        checkOutput("reset_strobes",
                    {27'd0, bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.reg_we}, 32'd0);

        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("idle_without_start", 32'(bus.state), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;

        // Four plain ALU ops, back-to-back fetches
        for (int k = 0; k < 4; k++) applyStimulus(aluOp(), 0, 0);
        // Fetch stalled for three cycles
        applyStimulus(aluOp(), 3, 0);

        // Set zero, then branch on zero (taken) and on not-zero (not taken)
        i = aluOp();
        i.setf = 1'b1;
        i.aflags = 3'b010;
        applyStimulus(i, 0, 0);
        i = aluOp();
        i.cond = 3'b001;
        i.jaddr = 32'h40;
        applyStimulus(i, 1, 0);
        i.cond = 3'b010;
        i.jaddr = 32'h80;
        applyStimulus(i, 0, 0);
        // Reserved codes are never taken, whatever the flags
        i = aluOp();
        i.setf = 1'b1;
        i.aflags = 3'b111;
        applyStimulus(i, 0, 0);
        i = aluOp();
        i.cond = 3'b110;
        i.jaddr = 32'h500;
        applyStimulus(i, 0, 0);
        i.cond = 3'b111;
        applyStimulus(i, 0, 0);

        // Register-indirect unconditional jump
        i = aluOp();
        i.uncond = 1'b1;
        i.adsel = 1'b1;
        i.alu = 32'h1234;
        i.jaddr = 32'h9999;
        applyStimulus(i, 0, 0);

        // Store with two stall cycles, then a load with one stall cycle
        i = aluOp();
        i.wr = 1'b0;
        i.mem = 1'b1;
        i.store = 1'b1;
        applyStimulus(i, 0, 2);
        i.wr = 1'b1;
        i.store = 1'b0;
        applyStimulus(i, 0, 1);

        // Randomized instruction mix
        for (int k = 0; k < 60; k++)
            applyStimulus(randInstr(), $urandom_range(3), $urandom_range(3));

        // PC wrap from 0xFFFF_FFFF to 0
        i = aluOp();
        i.uncond = 1'b1;
        i.jaddr = 32'hFFFF_FFFF;
        applyStimulus(i, 0, 0);
        applyStimulus(aluOp(), 0, 0);

        @(negedge clk);
        checkOutput("wrap_pc_zero", bus.pc, 32'h0);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);

        // HALT holds the pc and ignores start
        halt_pc  = m_pc;
        halt_ret = m_retired;
        i = aluOp();
        i.halt = 1'b1;
        applyStimulus(i, 1, 0);
        bus.start = 1'b1;
        repeat (4) tick();
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("halt_state", 32'(bus.state), 32'd6);
        checkOutput("halt_flag", 32'(bus.halted), 32'd1);
        checkOutput("halt_pc", bus.pc, halt_pc);
        checkOutput("halt_retired", bus.retired, halt_ret);
        checkOutput("halt_strobes",
                    {27'd0, bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.reg_we}, 32'd0);

        // Reset out of HALT, then reset in the middle of a memory access
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        resetModel();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        applyStimulus(aluOp(), 0, 0);
        i = aluOp();
        i.mem = 1'b1;
        i.store = 1'b1;
        driveFields(i);
        bus.imem_ready = 1'b1;
        waitState(3'd4, "enter_mem");
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        tick();
        checkOutput("mem_dmem_req_held", 32'(bus.dmem_req), 32'd1);
        rst_n = 1'b0;
        tick();
        checkOutput("midmem_reset_state", 32'(bus.state), 32'd0);
        checkOutput("midmem_reset_dmem_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("midmem_reset_dmem_we", 32'(bus.dmem_we), 32'd0);
        checkOutput("midmem_reset_pc", bus.pc, 32'h0);
        checkOutput("midmem_reset_retired", bus.retired, 32'd0);
        rst_n = 1'b1;
        resetModel();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        applyStimulus(aluOp(), 0, 0);
        repeat (2) tick();
        checkOutput("final_scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
